updown_counter_mod: RTL
=======================

Name: updown_counter_mod

Overview:
Parametrised synchronous up/down counter with a runtime step size, a modulus limit, a parallel load and a registered wrap flag. It is the generalised successor of the fixed 4-bit step-1/step-2 up/down counter: width, modulus and step range are parameters, and load and wrap detection are added. It feeds timers, address generators and display sequencers in lab designs.

Parameters:
WIDTH, 8, counter width in bits (2..32).
LIMIT, 2**WIDTH-1, largest count value; the count range is 0..LIMIT and the modulus is LIMIT+1 (1 <= LIMIT <= 2**WIDTH-1).
STEP_W, 3, width of the step input (1 <= STEP_W <= WIDTH).
RST_VAL, 0, value of count after reset (must be <= LIMIT).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  count enable
down  input  1  0 = count up, 1 = count down
step  input  STEP_W  increment/decrement amount
load  input  1  parallel load strobe
din  input  WIDTH  load value
count  output  WIDTH  registered counter value
wrap  output  1  registered 1-cycle pulse; the last update crossed the range boundary
at_max  output  1  combinational, count == LIMIT
at_min  output  1  combinational, count == 0

Behaviour:
- Reset: one clock and a synchronous active-high reset (clk, rst). On a rising clk edge with rst=1: count <= RST_VAL, wrap <= 0.
- Priority on each rising edge: rst > load > en > hold.
- Load: count <= min(din, LIMIT); wrap <= 0. Any en, down or step value is ignored in that cycle.
- Effective step: s = min(step, LIMIT). This clamp guarantees a single conditional add or subtract is enough to wrap.
- Up (en=1, down=0):
  - Compute t = count + s in WIDTH+1 bits.
  - If t > LIMIT: count <= t - (LIMIT+1), wrap <= 1.
  - Otherwise: count <= t, wrap <= 0.
- Down (en=1, down=1):
  - If count >= s: count <= count - s, wrap <= 0.
  - Otherwise: count <= count + (LIMIT+1) - s, computed in WIDTH+1 bits, and wrap <= 1.
- step=0 with en=1: count unchanged, wrap <= 0.
- Hold (en=0, load=0): count unchanged, wrap <= 0. wrap is therefore high for exactly one cycle per boundary crossing.
- Latency: count and wrap update on the edge following the sampled inputs. at_max and at_min follow count with no additional delay.
- Direction or step changes take effect on the next edge; no pipeline state exists.
- Reset mid-operation: any pending wrap pulse is cleared in the same edge. The first count after reset release starts from RST_VAL.
- No internal states beyond the count and wrap registers; all next-state logic is combinational from the current inputs.

Optional Feature:
Macro: UDC_SAT_EN.
- Defined:
  - Adds input port sat (1 bit, placed after down).
  - With sat=1, the counter saturates instead of wrapping: up clamps to LIMIT, down clamps to 0.
  - wrap is then asserted for one cycle when a clamp actually occurred, i.e. the unclamped result would have crossed the boundary.
  - With sat=0, behaviour equals the non-saturating description.
- Not defined: no sat port; the counter always wraps modulo LIMIT+1.

Test Plan:
1. WIDTH=4, LIMIT=15, RST_VAL=0. Assert rst for 2 cycles, then en=1, down=0, step=1 for 16 cycles -> count runs 1..15, then 0. wrap=1 only in the cycle count shows 0; at_max=1 while count=15.
2. LIMIT=9 (decade). count=8, up, step=3 -> count=1, wrap=1. Then down, step=2 -> count=9, wrap=1. Then down, step=2 -> count=7, wrap=0.
3. Step clamp: LIMIT=5, STEP_W=3, step=7, count=2, up -> s=5, count=1, wrap=1.
4. Priority: load=1, din=200, LIMIT=99, en=1 in the same cycle -> count=99, wrap=0. Next cycle rst=1 with load=1 -> count=RST_VAL, wrap=0.
5. Hold and zero step: en=0 for 5 cycles, then en=1 with step=0 -> count constant, wrap stays 0 throughout.
6. With UDC_SAT_EN, sat=1, LIMIT=15: count=14, up, step=4 -> count=15, wrap=1. Repeat -> count stays 15, wrap=1. Down from 1 with step=3 -> count=0, wrap=1.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with runtime step, parallel load and a registered wrap pulse.
// Optional saturating mode (adds port sat) is enabled by defining UDC_SAT_EN.
module updown_counter_mod #(
  parameter int unsigned      WIDTH   = 8,
  parameter longint unsigned  LIMIT   = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned      STEP_W  = 3,
  parameter longint unsigned  RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              down,
`ifdef UDC_SAT_EN
  input  logic              sat,
`endif
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(LIMIT);
  localparam logic [WIDTH:0]   W_MOD = (WIDTH + 1)'(LIMIT + 64'd1);
  localparam logic [WIDTH-1:0] W_RST = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH-1:0] w_step_ext;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_sum;
  logic             w_up_cross;
  logic             w_dn_cross;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;
  logic [WIDTH-1:0] w_din_clamp;
  logic             w_sat;

`ifdef UDC_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  // Clamping the step to LIMIT keeps any single crossing within one modulus.
  assign w_step_ext  = WIDTH'(step);
  assign w_s         = (w_step_ext > W_LIM) ? W_LIM : w_step_ext;
  assign w_din_clamp = (din > W_LIM) ? W_LIM : din;

  assign w_sum      = {1'b0, r_count} + {1'b0, w_s};
  assign w_up_cross = (w_sum > {1'b0, W_LIM});
  assign w_dn_cross = (r_count < w_s);

  always_comb begin
    w_up_val = w_sum[WIDTH-1:0];
    if (w_up_cross) begin
      w_up_val = w_sat ? W_LIM : WIDTH'(w_sum - W_MOD);
    end
  end

  always_comb begin
    w_dn_val = r_count - w_s;
    if (w_dn_cross) begin
      w_dn_val = w_sat ? '0 : WIDTH'({1'b0, r_count} + W_MOD - {1'b0, w_s});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= W_RST;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_din_clamp;
      r_wrap  <= 1'b0;
    end else if (en) begin
      if (down) begin
        r_count <= w_dn_val;
        r_wrap  <= w_dn_cross;
      end else begin
        r_count <= w_up_val;
        r_wrap  <= w_up_cross;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count  = r_count;
  assign wrap   = r_wrap;
  assign at_max = (r_count == W_LIM);
  assign at_min = (r_count == '0);

endmodule
